// File: rtl/tetris_pkg.sv
// Shared types and constants for the Tetris board renderer.
// Holds cell/colour types, board geometry, palette and region classes.
package tetris_pkg;

  typedef logic [2:0]  cell_t;
  typedef logic [23:0] rgb_t;

  localparam int BOARD_COLS = 10;
  localparam int BOARD_ROWS = 20;
  localparam int H_ACTIVE   = 640;
  localparam int V_ACTIVE   = 480;

  localparam rgb_t PAL_0 = 24'h000000;
  localparam rgb_t PAL_1 = 24'h00FFFF;
  localparam rgb_t PAL_2 = 24'hFFFF00;
  localparam rgb_t PAL_3 = 24'h800080;
  localparam rgb_t PAL_4 = 24'h00FF00;
  localparam rgb_t PAL_5 = 24'hFF0000;
  localparam rgb_t PAL_6 = 24'h0000FF;
  localparam rgb_t PAL_7 = 24'hFF8000;

  localparam rgb_t GRID_RGB = 24'h404040;

  typedef enum logic [1:0] {
    RG_BG,
    RG_BOARD,
    RG_BORDER
  } region_t;

endpackage

// File: rtl/tetris_palette.sv
// Cell code to RGB lookup, purely combinational.
// Ports: code_i (3-bit cell code) -> rgb_o (24-bit colour).
module tetris_palette
  import tetris_pkg::*;
(
  input  logic [2:0]  code_i,
  output logic [23:0] rgb_o
);

  always_comb begin
    rgb_o = PAL_0;
    unique case (code_i)
      3'd0: rgb_o = PAL_0;
      3'd1: rgb_o = PAL_1;
      3'd2: rgb_o = PAL_2;
      3'd3: rgb_o = PAL_3;
      3'd4: rgb_o = PAL_4;
      3'd5: rgb_o = PAL_5;
      3'd6: rgb_o = PAL_6;
      3'd7: rgb_o = PAL_7;
    endcase
  end

endmodule

// File: rtl/tetris_board_renderer.sv
// 3-stage pixel colour pipeline: board cells, border ring, background.
// In: clk, rst_n, pix_x/pix_y, hs_in/vs_in/blank_n_in, cell_data.
// Out: cell_addr, R/G/B, hs_out/vs_out/blank_n_out, frame_start.
// Optional 1-pixel grid on empty cells: define TETRIS_GRID_EN.
module tetris_board_renderer
  import tetris_pkg::*;
#(
  parameter int          CELL_PX    = 20,
  parameter int          BOARD_X0   = 220,
  parameter int          BOARD_Y0   = 40,
  parameter int          BORDER_PX  = 2,
  parameter logic [23:0] BORDER_RGB = 24'hFFFFFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       hs_in,
  input  logic       vs_in,
  input  logic       blank_n_in,
  output logic [7:0] cell_addr,
  input  logic [2:0] cell_data,
  output logic [7:0] R,
  output logic [7:0] G,
  output logic [7:0] B,
  output logic       hs_out,
  output logic       vs_out,
  output logic       blank_n_out,
  output logic       frame_start
);

  localparam int SW = $clog2(CELL_PX);
  localparam int BW = BOARD_COLS * CELL_PX;
  localparam int BH = BOARD_ROWS * CELL_PX;

  localparam logic [9:0] X0  = 10'(BOARD_X0);
  localparam logic [9:0] X1  = 10'(BOARD_X0 + BW);
  localparam logic [9:0] Y0  = 10'(BOARD_Y0);
  localparam logic [9:0] Y1  = 10'(BOARD_Y0 + BH);
  localparam logic [9:0] BX0 = 10'(BOARD_X0 - BORDER_PX);
  localparam logic [9:0] BX1 = 10'(BOARD_X0 + BW + BORDER_PX);
  localparam logic [9:0] BY0 = 10'(BOARD_Y0 - BORDER_PX);
  localparam logic [9:0] BY1 = 10'(BOARD_Y0 + BH + BORDER_PX);
  localparam logic [9:0] HA  = 10'(H_ACTIVE);
  localparam logic [9:0] VA  = 10'(V_ACTIVE);

  localparam logic [SW-1:0] SUB_LAST = SW'(CELL_PX - 1);
  localparam logic [3:0]    COL_LAST = 4'(BOARD_COLS - 1);
  localparam logic [7:0]    ROW_STEP = 8'(BOARD_COLS);

  // stage A state
  logic [SW-1:0] sub_x_q, sub_x_d;
  logic [3:0]    col_q, col_d;
  logic [SW-1:0] sub_y_q, sub_y_d;
  logic [7:0]    row_base_q, row_base_d;
  logic          row_valid_q, row_valid_d;
  logic [7:0]    addr_q, addr_d;
  region_t       reg_a_q, reg_a_d;
  logic          hs_a_q, vs_a_q, bl_a_q, fs_a_q;

  // stage B
  region_t       reg_b_q;
  logic          hs_b_q, vs_b_q, bl_b_q, fs_b_q;

  // stage C (outputs)
  rgb_t          rgb_q, rgb_d;
  logic          hs_c_q, vs_c_q, bl_c_q, fs_c_q;

  logic          in_col, in_row, in_ring, in_vis;
  logic          in_board;
  rgb_t          pal_rgb;

  assign in_col  = (pix_x >= X0) && (pix_x < X1);
  assign in_row  = (pix_y >= Y0) && (pix_y < Y1);
  assign in_vis  = (pix_x < HA) && (pix_y < VA);
  assign in_ring = (pix_x >= BX0) && (pix_x < BX1) &&
                   (pix_y >= BY0) && (pix_y < BY1);
  assign in_board = in_col && in_row && row_valid_q;

  // column tracking: col_d/sub_x_d describe the current pixel
  always_comb begin
    sub_x_d = sub_x_q;
    col_d   = col_q;
    if (pix_x == X0) begin
      sub_x_d = '0;
      col_d   = '0;
    end else if (sub_x_q == SUB_LAST) begin
      sub_x_d = '0;
      if (col_q != COL_LAST)
        col_d = col_q + 4'd1;
    end else begin
      sub_x_d = sub_x_q + SW'(1);
    end
  end

  // row tracking advances once per line, at pix_x == 0
  always_comb begin
    sub_y_d     = sub_y_q;
    row_base_d  = row_base_q;
    row_valid_d = row_valid_q;
    if (pix_x == '0) begin
      if (pix_y == Y0) begin
        sub_y_d     = '0;
        row_base_d  = '0;
        row_valid_d = 1'b1;
      end else begin
        if (sub_y_q == SUB_LAST) begin
          sub_y_d = '0;
          if (row_valid_q)
            row_base_d = row_base_q + ROW_STEP;
        end else begin
          sub_y_d = sub_y_q + SW'(1);
        end
        if (pix_y == Y1)
          row_valid_d = 1'b0;
      end
    end
  end

  // address only moves inside the board so memory reads stay put outside
  always_comb begin
    addr_d = addr_q;
    if (in_board)
      addr_d = row_base_q + 8'(col_d);
  end

  // inside the board rectangle is never border, even with row_valid low
  always_comb begin
    reg_a_d = RG_BG;
    if (in_vis) begin
      if (in_col && in_row)
        reg_a_d = row_valid_q ? RG_BOARD : RG_BG;
      else if (in_ring)
        reg_a_d = RG_BORDER;
    end
  end

  tetris_palette u_pal (
    .code_i (cell_data),
    .rgb_o  (pal_rgb)
  );

`ifdef TETRIS_GRID_EN
  logic grid_a_q, grid_b_q;
`endif

  always_comb begin
    rgb_d = '0;
    if (bl_b_q) begin
      unique case (reg_b_q)
        RG_BORDER: rgb_d = BORDER_RGB;
        RG_BOARD:  rgb_d = pal_rgb;
        default:   rgb_d = '0;
      endcase
`ifdef TETRIS_GRID_EN
      if (reg_b_q == RG_BOARD && cell_data == '0 && grid_b_q)
        rgb_d = GRID_RGB;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sub_x_q     <= '0;
      col_q       <= '0;
      sub_y_q     <= '0;
      row_base_q  <= '0;
      row_valid_q <= 1'b0;
      addr_q      <= '0;
      reg_a_q     <= RG_BG;
      hs_a_q      <= 1'b1;
      vs_a_q      <= 1'b1;
      bl_a_q      <= 1'b0;
      fs_a_q      <= 1'b0;
      reg_b_q     <= RG_BG;
      hs_b_q      <= 1'b1;
      vs_b_q      <= 1'b1;
      bl_b_q      <= 1'b0;
      fs_b_q      <= 1'b0;
      rgb_q       <= '0;
      hs_c_q      <= 1'b1;
      vs_c_q      <= 1'b1;
      bl_c_q      <= 1'b0;
      fs_c_q      <= 1'b0;
`ifdef TETRIS_GRID_EN
      grid_a_q    <= 1'b0;
      grid_b_q    <= 1'b0;
`endif
    end else begin
      sub_x_q     <= sub_x_d;
      col_q       <= col_d;
      sub_y_q     <= sub_y_d;
      row_base_q  <= row_base_d;
      row_valid_q <= row_valid_d;
      addr_q      <= addr_d;
      reg_a_q     <= reg_a_d;
      hs_a_q      <= hs_in;
      vs_a_q      <= vs_in;
      bl_a_q      <= blank_n_in;
      fs_a_q      <= (pix_x == '0) && (pix_y == '0);
      reg_b_q     <= reg_a_q;
      hs_b_q      <= hs_a_q;
      vs_b_q      <= vs_a_q;
      bl_b_q      <= bl_a_q;
      fs_b_q      <= fs_a_q;
      rgb_q       <= rgb_d;
      hs_c_q      <= hs_b_q;
      vs_c_q      <= vs_b_q;
      bl_c_q      <= bl_b_q;
      fs_c_q      <= fs_b_q;
`ifdef TETRIS_GRID_EN
      grid_a_q    <= (sub_x_d == '0) || (sub_y_q == '0);
      grid_b_q    <= grid_a_q;
`endif
    end
  end

  assign cell_addr   = addr_q;
  assign R           = rgb_q[23:16];
  assign G           = rgb_q[15:8];
  assign B           = rgb_q[7:0];
  assign hs_out      = hs_c_q;
  assign vs_out      = vs_c_q;
  assign blank_n_out = bl_c_q;
  assign frame_start = fs_c_q;

endmodule

// File: tb/tb_tetris_board_renderer.sv
// Bench for tetris_board_renderer: compressed frame scans with random
// memory and blanking, compared to an arithmetic screen model.
module tb_tetris_board_renderer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] pix_x, pix_y;
  logic       hs_in, vs_in, blank_n_in;
  logic [7:0] cell_addr;
  logic [2:0] cell_data;
  logic [7:0] R, G, B;
  logic       hs_out, vs_out, blank_n_out, frame_start;

  always #20 clk = ~clk;

  tetris_board_renderer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .hs_in       (hs_in),
    .vs_in       (vs_in),
    .blank_n_in  (blank_n_in),
    .cell_addr   (cell_addr),
    .cell_data   (cell_data),
    .R           (R),
    .G           (G),
    .B           (B),
    .hs_out      (hs_out),
    .vs_out      (vs_out),
    .blank_n_out (blank_n_out),
    .frame_start (frame_start)
  );

  logic [2:0] mem [256];
  always @(posedge clk) cell_data <= mem[cell_addr];

  logic [23:0] pal [8];
  int n_assert = 0;
  int n_fail   = 0;
  int n        = 0;
  int fs_cnt   = 0;
  logic ok     = 1'b0;

  logic [23:0] e_rgb [4];
  logic [3:0]  e_sig [4];
  logic        e_ach [4];
  logic [7:0]  e_adr [4];

  function automatic logic [23:0] model(int x, int y, logic bl, logic okv);
    int c, rw;
    logic inb, ring;
    logic [2:0] code;
    inb  = x >= 220 && x < 420 && y >= 40 && y < 440;
    ring = !inb && x >= 218 && x < 422 && y >= 38 && y < 442;
    if (!bl) return 24'h0;
    if (ring) return 24'hFFFFFF;
    if (!inb || !okv) return 24'h0;
    c    = (x - 220) / 20;
    rw   = (y - 40) / 20;
    code = mem[rw * 10 + c];
`ifdef TETRIS_GRID_EN
    if (code == 3'd0 && ((x - 220) % 20 == 0 || (y - 40) % 20 == 0))
      return 24'h404040;
`endif
    return pal[code];
  endfunction

  function automatic logic rbl(int x, int y);
    return (x < 640 && y < 480) && ($urandom % 16 != 0);
  endfunction

  task automatic step(input logic r, input int x, input int y,
                      input logic bl);
    int s3, s2, s1, s0;
    logic hs, vs, inb;
    @(posedge clk);
    #1;
    s3 = (n + 1) % 4;
    s2 = (n + 2) % 4;
    s1 = (n + 3) % 4;
    s0 = n % 4;
    if (frame_start === 1'b1) fs_cnt++;
    if (n >= 3) begin
      n_assert++;
      assert ({R, G, B} === e_rgb[s3]) else begin
        n_fail++;
        $error("FAIL rgb step %0d: got %h expected %h",
               n, {R, G, B}, e_rgb[s3]);
      end
      n_assert++;
      assert ({hs_out, vs_out, blank_n_out, frame_start} === e_sig[s3])
      else begin
        n_fail++;
        $error("FAIL sync step %0d: got %b expected %b", n,
               {hs_out, vs_out, blank_n_out, frame_start}, e_sig[s3]);
      end
    end
    if (n >= 1 && e_ach[s1]) begin
      n_assert++;
      assert (cell_addr === e_adr[s1]) else begin
        n_fail++;
        $error("FAIL addr step %0d: got %0d expected %0d",
               n, cell_addr, e_adr[s1]);
      end
    end
    hs = !(x >= 664 && x <= 768);
    vs = !(y == 490 || y == 491);
    if (!r) begin
      ok       = 1'b0;
      e_rgb[s0] = 24'h0;
      e_sig[s0] = 4'b1100;
      e_ach[s0] = 1'b1;
      e_adr[s0] = 8'd0;
      if (n >= 1) begin
        e_rgb[s1] = 24'h0;
        e_sig[s1] = 4'b1100;
      end
      if (n >= 2) begin
        e_rgb[s2] = 24'h0;
        e_sig[s2] = 4'b1100;
      end
    end else begin
      if (x == 0 && y == 40) ok = 1'b1;
      if (x == 0 && y == 440) ok = 1'b0;
      inb = ok && x >= 220 && x < 420 && y >= 40 && y < 440;
      e_rgb[s0] = model(x, y, bl, ok);
      e_sig[s0] = {hs, vs, bl, (x == 0 && y == 0)};
      e_ach[s0] = inb;
      e_adr[s0] = 8'(((y - 40) / 20) * 10 + (x - 220) / 20);
    end
    rst_n      = r;
    pix_x      = 10'(x);
    pix_y      = 10'(y);
    hs_in      = hs;
    vs_in      = vs;
    blank_n_in = bl;
    n++;
  endtask

  task automatic frame(input int rst_line);
    for (int y = 0; y < 525; y++) begin
      logic sel, b;
      step(1'b1, 0, y, 1'(y < 480));
      if (y == rst_line) begin
        step(1'b0, 0, y, 1'b1);
        step(1'b0, 0, y, 1'b1);
        step(1'b1, 0, y, 1'(y < 480));
      end
      if (y == 100) begin
        for (int x = 1; x < 800; x++) begin
          b = rbl(x, y);
          if (x == 100 || x == 219 || x == 420) b = 1'b1;
          if (x == 300) b = 1'b0;
          step(1'b1, x, y, b);
        end
      end else begin
        sel = (y >= 38 && y <= 41) || (y >= 59 && y <= 61) ||
              y == 200 || (y >= 439 && y <= 441) ||
              (y < 480 && $urandom % 16 == 0);
        if (sel)
          for (int x = 214; x < 426; x++) step(1'b1, x, y, rbl(x, y));
      end
    end
  endtask

  initial begin
    pal[0] = 24'h000000; pal[1] = 24'h00FFFF;
    pal[2] = 24'hFFFF00; pal[3] = 24'h800080;
    pal[4] = 24'h00FF00; pal[5] = 24'hFF0000;
    pal[6] = 24'h0000FF; pal[7] = 24'hFF8000;
    for (int i = 0; i < 256; i++) mem[i] = 3'($urandom);
    mem[0]   = 3'd1;
    mem[199] = 3'($urandom_range(1, 7));
    rst_n = 1'b0; pix_x = '0; pix_y = '0;
    hs_in = 1'b1; vs_in = 1'b1; blank_n_in = 1'b0;

    repeat (5) step(1'b0, 0, 0, 1'b0);

    fs_cnt = 0;
    frame(-1);
    n_assert++;
    assert (fs_cnt == 1) else begin
      n_fail++;
      $error("FAIL frame_start f1: got %0d expected 1", fs_cnt);
    end

    fs_cnt = 0;
    frame(200);
    n_assert++;
    assert (fs_cnt == 1) else begin
      n_fail++;
      $error("FAIL frame_start f2: got %0d expected 1", fs_cnt);
    end

    fs_cnt = 0;
    frame(-1);
    n_assert++;
    assert (fs_cnt == 1) else begin
      n_fail++;
      $error("FAIL frame_start f3: got %0d expected 1", fs_cnt);
    end

    repeat (4) step(1'b1, 5, 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/tetris_board_renderer.md
Name: tetris_board_renderer

Overview:
- Pixel-colour stage sitting directly downstream of the 640x480 VGA timing generator.
- Consumes the generator's pixel coordinates and sync/blank signals, and reads the Tetris board cell memory through a 1-cycle synchronous read port.
- Emits 24-bit RGB together with sync/blank signals delayed to match its 3-cycle pipeline.
- Draws the 10x20 board, a white border around it, and a black background.

Parameters:
- CELL_PX, 20, pixel edge length of one square cell
- BOARD_X0, 220, first active pixel column of the board
- BOARD_Y0, 40, first active pixel line of the board
- BORDER_PX, 2, border thickness drawn just outside the board
- BORDER_RGB, 24'hFFFFFF, border colour

Ports:
- clk  in  1  pixel clock (25 MHz domain, same as timing generator)
- rst_n  in  1  synchronous active-low reset
- pix_x  in  10  current pixel column, 0..799
- pix_y  in  10  current line, 0..524
- hs_in  in  1  horizontal sync from timing generator, active-low
- vs_in  in  1  vertical sync, active-low
- blank_n_in  in  1  1 = active video
- cell_addr  out  8  board memory address, row*10+col, 0..199
- cell_data  in  3  cell code, valid 1 cycle after cell_addr
- R, G, B  out  8 each  pixel colour
- hs_out, vs_out, blank_n_out  out  1 each  hs_in/vs_in/blank_n_in delayed 3 cycles
- frame_start  out  1  one-cycle pulse aligned with output pixel (0,0)

Behaviour:
- Reset: clk and rst_n only (one clock; reset synchronous, active-low). While rst_n=0 at a clk edge:
  - All pipeline registers clear.
  - R=G=B=0, hs_out=1, vs_out=1, blank_n_out=0, frame_start=0, cell_addr=0, row_valid=0.
- Latency: inputs sampled at edge t; cell_addr is valid after edge t+1; cell_data is sampled at edge t+2; all outputs are registered and valid after edge t+3. Throughput is one pixel per clock, with no stalls.
- Stage A, column tracking (no dividers):
  - pix_x==BOARD_X0: col=0, sub_x=0.
  - Otherwise sub_x increments. When sub_x==CELL_PX-1 it wraps to 0 and col increments.
  - in_col is true for BOARD_X0 <= pix_x < BOARD_X0+10*CELL_PX.
- Stage A, row tracking, updated only when pix_x==0:
  - pix_y==BOARD_Y0: row=0, sub_y=0, row_base=0, row_valid=1.
  - Otherwise sub_y increments. On wrap, row increments and row_base += 10.
  - row_valid clears at pix_y==BOARD_Y0+20*CELL_PX.
- cell_addr = row_base + col (8-bit), registered in stage A. It holds its previous value when the pixel is outside the board.
- Stage B: carries region class {BOARD, BORDER, BACKGROUND}, edge flags and syncs.
  - BOARD requires in_col, the row window and row_valid.
  - BORDER is the BORDER_PX ring immediately outside the board rectangle, evaluated combinationally from pix_x/pix_y.
- Stage C output priority:
  - blank=0 gives 000000.
  - BORDER gives BORDER_RGB.
  - BOARD gives palette(cell_data).
  - Otherwise 000000.
- Palette: 0 000000, 1 00FFFF, 2 FFFF00, 3 800080, 4 00FF00, 5 FF0000, 6 0000FF, 7 FF8000.
- Reset mid-frame: row_valid=0, so the board area renders black (border still drawn) until the next line pix_y==BOARD_Y0 at pix_x==0.
- Boundaries:
  - pix_x=BOARD_X0+199 is the last board pixel; the next pixel is border.
  - Column wrap at col 9 / sub_x CELL_PX-1 is the board's right edge; col does not increment past 9 (saturate).

Optional Feature:
- Macro: TETRIS_GRID_EN.
- Defined: empty cells (code 0) inside BOARD with sub_x==0 or sub_y==0 render 404040, giving 1-pixel grid lines. Filled cells are unaffected.
- Undefined: empty cells are solid 000000, and the sub-counter edge flags are not carried past stage A.

Decomposition:
- Package tetris_pkg holds:
  - typedef cell_t (logic [2:0]) and typedef rgb_t (logic [23:0]).
  - Constants BOARD_COLS=10, BOARD_ROWS=20, H_ACTIVE=640, V_ACTIVE=480.
  - Palette constants and enum region_t.
- Sub-module tetris_palette: combinational cell_t -> rgb_t, reused by the next-piece preview.

Test Plan:
- Reset: rst_n=0 for 5 clocks -> RGB=000000, hs_out=vs_out=1, blank_n_out=0, cell_addr=0, frame_start=0.
- Latency/lookup: full frame sweep, memory model addr 0 = code 1 -> cell_addr=0 one cycle after input (220,40); output pixel (220,40) = 00FFFF three cycles after input.
- Addressing: input (240,60) -> cell_addr=11; input (419,439) -> cell_addr=199, output = palette of addr 199.
- Regions: (219,100) and (420,100) -> FFFFFF; (100,100) -> 000000; blank_n_in=0 at (300,100) -> 000000.
- Sync alignment: hs_in low for x 664..768 -> hs_out low for exactly 105 clocks starting 3 clocks later; frame_start pulses once per 420000 clocks.
- Mid-frame reset: rst_n pulsed low at line 200 -> board pixels 000000 for the rest of the frame, border intact; correct cells return from line 40 of the next frame.
